config_chain_ctrl: RTL and testbench

CONFIG_CHAIN_CTRL -- requirements
Module: config_chain_ctrl

---
 rtl/config_chain_ctrl_if.sv | 25 ++
 rtl/config_chain_ctrl.sv | 176 +++++++++++++++++
 tb/tb_config_chain_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// config_chain_ctrl_if
// Host word-stream handshake of the configuration chain controller.
//
// Handshake: the host presents word_data with word_valid=1; the controller
// raises word_ready when it can take a word. A word transfers on every rising
// clock edge where word_valid=1 and word_ready=1. The host holds word_data
// stable while word_valid=1 and the word has not yet transferred; word_data is
// a don't-care while word_valid=0.
//
// Signals:
//   word_valid  host -> ctrl   word available
//   word_data   host -> ctrl   configuration word, shifted into the chain LSB first
//   word_ready  ctrl -> host   controller accepts word_data this cycle
// -----------------------------------------------------------------------------
interface config_chain_ctrl_if #(
   parameter int WORD_W = 8
) ();
   logic              word_valid;
   logic [WORD_W-1:0] word_data;
   logic              word_ready;

   modport master (output word_valid, output word_data, input word_ready);
   modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/config_chain_ctrl.sv
// -----------------------------------------------------------------------------
// config_chain_ctrl
// Loads a serial chain of CHAIN_LEN resettable flops from a host word stream.
// A sequence clears the chain (2 cycles of chain_rst), then shifts exactly
// CHAIN_LEN bits into the chain head, one bit per enabled cycle, while checking
// that the chain tail only ever returns zeros (the chain was just cleared).
//
// Ports:
//   CK, RST      clock, synchronous active-high reset
//   start        begin a load sequence (honoured only when idle)
//   abort        terminate a sequence in CLEAR or LOAD
//   host         word stream (slave side of config_chain_ctrl_if)
//   chain_rst    reset of every chain cell
//   chain_en     shift/clock enable of every chain cell
//   chain_d      serial data into the chain head
//   chain_q      Q of the chain tail cell
//   busy         sequence in progress
//   done         one-cycle pulse on completion
//   err          sticky integrity error, cleared by the next start
//   state_o      current FSM state for debug/observation
// -----------------------------------------------------------------------------
module config_chain_ctrl #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic                 CK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 abort,
   config_chain_ctrl_if.slave   host,
   output logic                 chain_rst,
   output logic                 chain_en,
   output logic                 chain_d,
   input  logic                 chain_q,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           state_o
);

   localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
   localparam int CW        = $clog2(WORD_W + 1);
   localparam int NWW       = $clog2(NW + 1);

   // Keeps only the bits of the final word that still fit in the chain.
   localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);
   localparam logic [CW-1:0]     FULL_CNT  = CW'(WORD_W);
   localparam logic [CW-1:0]     LAST_CNT  = CW'(LAST_BITS);
   localparam logic [NWW-1:0]    NW_CNT    = NWW'(NW);
   localparam logic [NWW-1:0]    LAST_IDX  = NWW'(NW - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_LOAD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q;
   logic               clr_cnt_q;
   logic [WORD_W-1:0]  sreg_q;
   logic [CW-1:0]      bits_q;
   logic [NWW-1:0]     words_q;
   logic               err_q;
   logic               busy_q;
   logic               done_q;
   logic               chain_rst_q;

   logic               shift_en;
   logic               ready_base;
   logic               accept;
   logic               last_word;
   logic               final_shift;
   logic [WORD_W-1:0]  load_word;
   logic [CW-1:0]      load_cnt;

   // The shift register only holds bits in LOAD, so a non-zero count alone
   // decides the enable.
   assign shift_en   = (bits_q != '0);
   // Ready while the register is empty or on its last bit, so a new word can
   // replace the outgoing bit on the same edge without a bubble.
   assign ready_base = (state_q == S_LOAD) && (words_q < NW_CNT) && (bits_q <= CW'(1));
   assign host.word_ready = ready_base && !abort;
   assign accept     = host.word_ready && host.word_valid;
   assign last_word  = (words_q == LAST_IDX);
   assign load_word  = last_word ? (host.word_data & LAST_MASK) : host.word_data;
   assign load_cnt   = last_word ? LAST_CNT : FULL_CNT;
   // With all words taken, the last bit leaving is the CHAIN_LEN-th shift.
   assign final_shift = shift_en && (bits_q == CW'(1)) && (words_q == NW_CNT);

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= 1'b0;
         sreg_q      <= '0;
         bits_q      <= '0;
         words_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         chain_rst_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q     <= S_CLEAR;
                  clr_cnt_q   <= 1'b0;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
                  chain_rst_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (abort) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  chain_rst_q <= 1'b0;
                  clr_cnt_q   <= 1'b0;
               end else if (clr_cnt_q) begin
                  state_q     <= S_LOAD;
                  chain_rst_q <= 1'b0;
                  clr_cnt_q   <= 1'b0;
               end else begin
                  clr_cnt_q <= 1'b1;
               end
            end
            S_LOAD: begin
               // The tail is sampled on every shift, including an aborted one.
               if (shift_en && chain_q) begin
                  err_q <= 1'b1;
               end
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  sreg_q  <= '0;
                  bits_q  <= '0;
                  words_q <= '0;
               end else begin
                  if (accept) begin
                     sreg_q  <= load_word;
                     bits_q  <= load_cnt;
                     words_q <= words_q + NWW'(1);
                  end else if (shift_en) begin
                     sreg_q <= sreg_q >> 1;
                     bits_q <= bits_q - CW'(1);
                  end
                  if (final_shift) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               words_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign chain_en  = shift_en;
   assign chain_d   = sreg_q[0];
   assign chain_rst = chain_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_config_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_config_chain_ctrl
// Bench for config_chain_ctrl with CHAIN_LEN=10, WORD_W=4 (three words, the
// last one carrying 2 useful bits). A behavioural model keeps the sequence
// phase and a queue of the bits still owed to the chain; every cycle the DUT
// outputs are compared against it. Directed sequences pin timing and bit order
// with literal values; a randomized phase adds stalls, aborts, stray starts and
// tail errors.
// -----------------------------------------------------------------------------
module tb_config_chain_ctrl;

   localparam int L  = 10;
   localparam int W  = 4;
   localparam int NW = 3;

   localparam int P_IDLE  = 0;
   localparam int P_CLEAR = 1;
   localparam int P_LOAD  = 2;
   localparam int P_DONE  = 3;

   // ---------------- clock / reset / DUT ----------------
   logic       CK = 1'b0;
   logic       RST;
   logic       start;
   logic       abort;
   logic       chain_q;
   logic       chain_rst, chain_en, chain_d, busy, done, err;
   logic [1:0] state_o;

   always #5 CK = ~CK;

   config_chain_ctrl_if #(.WORD_W(W)) host ();

   config_chain_ctrl #(.CHAIN_LEN(L), .WORD_W(W)) dut (
      .CK        (CK),
      .RST       (RST),
      .start     (start),
      .abort     (abort),
      .host      (host),
      .chain_rst (chain_rst),
      .chain_en  (chain_en),
      .chain_d   (chain_d),
      .chain_q   (chain_q),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .state_o   (state_o)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural model ----------------
   int         m_phase  = P_IDLE;
   int         m_clr    = 0;
   int         m_nacc   = 0;
   int         m_nshift = 0;
   logic       m_err    = 1'b0;
   logic [0:0] exp_q[$];          // bits accepted but not yet shifted into the chain

   function automatic logic m_ready();
      return (m_phase == P_LOAD) && (m_nacc < NW) && (exp_q.size() <= 1) && !abort;
   endfunction

   always @(posedge CK) begin : model
      logic en;
      logic acc;
      int   nb;
      cyc++;
      en  = (exp_q.size() > 0);
      acc = m_ready() && host.word_valid;
      if (RST) begin
         m_phase = P_IDLE; exp_q.delete(); m_nacc = 0; m_nshift = 0; m_err = 1'b0;
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin m_phase = P_CLEAR; m_clr = 2; m_err = 1'b0; end
            P_CLEAR: begin
               if (abort) m_phase = P_IDLE;
               else begin
                  m_clr--;
                  if (m_clr == 0) m_phase = P_LOAD;
               end
            end
            P_LOAD: begin
               if (en && chain_q) m_err = 1'b1;
               if (abort) begin
                  m_phase = P_IDLE; exp_q.delete(); m_nacc = 0; m_nshift = 0;
               end else begin
                  if (en) begin void'(exp_q.pop_front()); m_nshift++; end
                  if (acc) begin
                     nb = L - m_nacc * W;
                     if (nb > W) nb = W;
                     for (int b = 0; b < nb; b++) exp_q.push_back(host.word_data[b]);
                     m_nacc++;
                  end
                  if (m_nshift == L) m_phase = P_DONE;
               end
            end
            default: begin m_phase = P_IDLE; m_nacc = 0; m_nshift = 0; end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [0:0] log_q[$];          // chain_d values seen on enabled cycles
   int         done_cyc = -1;

   always @(negedge CK) begin
      if (chk_on) begin
         check("busy",       busy,            m_phase != P_IDLE);
         check("chain_rst",  chain_rst,       m_phase == P_CLEAR);
         check("chain_en",   chain_en,        exp_q.size() > 0);
         if (exp_q.size() > 0) check("chain_d", chain_d, exp_q[0]);
         check("word_ready", host.word_ready, m_ready());
         check("done",       done,            m_phase == P_DONE);
         check("err",        err,             m_err);
         if (chain_en) log_q.push_back(chain_d);
         if (done) done_cyc = cyc;
      end
   end

   // ---------------- chain tail stimulus ----------------
   bit inj_en  = 1'b0;
   int inj_at  = 0;
   bit rand_cq = 1'b0;

   always @(negedge CK) begin
      chain_q = (inj_en && m_phase == P_LOAD && exp_q.size() > 0 && m_nshift == inj_at)
                || (rand_cq && $urandom_range(0, 39) == 0);
   end

   // ---------------- host driver ----------------
   logic [W-1:0] host_q[$];
   int h_nacc      = 0;
   int stall_after = -1;
   int stall_len   = 0;
   int stall_cnt   = 0;
   bit rand_valid  = 1'b0;
   int start_edge  = 0;

   // Advance one cycle; returns 1 time unit after the next rising edge.
   task automatic cycle();
      logic acc;
      @(negedge CK);
      acc = host.word_valid && host.word_ready;
      if (stall_cnt > 0 && host.word_ready) stall_cnt--;
      if (acc) begin
         void'(host_q.pop_front());
         h_nacc++;
         if (h_nacc == stall_after) stall_cnt = stall_len;
      end
      @(posedge CK);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (stall_cnt > 0) host.word_valid = 1'b0;
      else if (rand_valid) host.word_valid = (host_q.size() > 0) && ($urandom_range(0, 2) != 0);
      else host.word_valid = (host_q.size() > 0);
      host.word_data = (host_q.size() > 0) ? host_q[0] : W'($urandom);
   endtask

   task automatic start_seq(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
      host_q.delete();
      host_q.push_back(w0);
      host_q.push_back(w1);
      host_q.push_back(w2);
      h_nacc = 0;
      log_q.delete();
      done_cyc = -1;
      start = 1'b1;
      cycle();
      start_edge = cyc;
   endtask

   task automatic wait_done(output int d_edge);
      for (int i = 0; i < 200; i++) begin
         if (done_cyc >= 0) break;
         cycle();
      end
      check("done_seen", done_cyc >= 0, 1'b1);
      d_edge = done_cyc - start_edge;
   endtask

   function automatic logic [L-1:0] packed_stream();
      logic [L-1:0] s = '0;
      foreach (log_q[i]) s = {s[L-2:0], log_q[i]};
      return s;
   endfunction

   // ---------------- main ----------------
   int d;

   initial begin
      RST = 1'b1; start = 1'b0; abort = 1'b0;
      host.word_valid = 1'b0; host.word_data = '0;
      @(posedge CK); #1;
      chk_on = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_chain_en", chain_en, 1'b0);
      check("rst_chain_rst", chain_rst, 1'b0);
      check("rst_word_ready", host.word_ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      cycle();
      RST = 1'b0;
      cycle();

      // Nominal load: done 13 edges after the start edge (cycle N+14).
      start_seq(4'hA, 4'h5, 4'hF);
      wait_done(d);
      check("nom_done_lat", d, L + 3);
      check("nom_en_cycles", log_q.size(), L);
      check("nom_stream", packed_stream(), 10'b0101101011);
      check("nom_err", err, 1'b0);
      repeat (2) cycle();

      // Starvation: 3 ready cycles without a word after word 1.
      stall_after = 1; stall_len = 3;
      start_seq(4'hA, 4'h5, 4'hF);
      wait_done(d);
      stall_after = -1;
      check("starve_done_lat", d, L + 6);
      check("starve_stream", packed_stream(), 10'b0101101011);
      check("starve_en_cycles", log_q.size(), L);
      repeat (2) cycle();

      // Broken chain: tail returns 1 on the 4th enabled cycle.
      inj_en = 1'b1; inj_at = 3;
      start_seq(4'h3, 4'hC, 4'h6);
      wait_done(d);
      inj_en = 1'b0;
      check("broken_err", err, 1'b1);
      check("broken_done_lat", d, L + 3);
      start_seq(4'h1, 4'h2, 4'h3);
      check("restart_err_clr", err, 1'b0);
      wait_done(d);
      repeat (2) cycle();

      // Abort during the 6th shift, then a fresh full sequence.
      start_seq(4'hA, 4'h5, 4'hF);
      for (int i = 0; i < 100; i++) begin
         if (m_phase == P_LOAD && m_nshift == 5 && exp_q.size() > 0) break;
         cycle();
      end
      check("abort_reached", m_nshift, 5);
      abort = 1'b1;
      cycle();
      check("abort_busy", busy, 1'b0);
      check("abort_ready", host.word_ready, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_en", chain_en, 1'b0);
      repeat (3) cycle();
      check("abort_no_done", done_cyc, -1);
      start_seq(4'hA, 4'h5, 4'hF);
      wait_done(d);
      check("post_abort_lat", d, L + 3);
      check("post_abort_stream", packed_stream(), 10'b0101101011);
      repeat (2) cycle();

      // Reset after two accepted words; the restart needs all three again.
      start_seq(4'h9, 4'h9, 4'h9);
      for (int i = 0; i < 100; i++) begin
         if (m_nacc == 2) break;
         cycle();
      end
      RST = 1'b1;
      cycle();
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_en", chain_en, 1'b0);
      check("mid_rst_ready", host.word_ready, 1'b0);
      check("mid_rst_rst", chain_rst, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_err", err, 1'b0);
      RST = 1'b0;
      host_q.delete();
      cycle();
      start_seq(4'hA, 4'h5, 4'hF);
      wait_done(d);
      check("post_rst_words", h_nacc, NW);
      check("post_rst_lat", d, L + 3);
      repeat (2) cycle();

      // Start pulsed during LOAD is ignored; word 3 upper bits never shift.
      start_seq(4'hA, 4'h5, 4'hF);
      for (int i = 0; i < 100; i++) begin
         if (m_phase == P_LOAD && m_nshift == 2) break;
         cycle();
      end
      start = 1'b1;
      cycle();
      wait_done(d);
      check("ign_start_lat", d, L + 3);
      check("ign_start_stream", packed_stream(), 10'b0101101011);
      repeat (2) cycle();

      // Randomized sequences against the model.
      for (int it = 0; it < 40; it++) begin
         rand_valid = 1'b1;
         rand_cq    = ($urandom_range(0, 3) == 0);
         start_seq(W'($urandom), W'($urandom), W'($urandom));
         for (int c = 0; c < 300; c++) begin
            if (m_phase == P_IDLE) break;
            if ($urandom_range(0, 9) == 0) start = 1'b1;
            if ($urandom_range(0, 59) == 0) abort = 1'b1;
            cycle();
         end
         rand_cq = 1'b0;
         rand_valid = 1'b0;
         host_q.delete();
         check("rand_end_busy", busy, 1'b0);
         abort = ($urandom_range(0, 1) == 1);
         cycle();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
